mem_access_unit: RTL and testbench

Memory-access stage directly downstream of the I-type load decoder (and the S-type store decoder).
- Consumes the decoded mem_op / mem_sel / rd together with the ALU-computed effective address and the store data.
- Drives a single-port, word-addressed data-memory bus with a req/ack handshake.
- Returns sign- or zero-extended load results to writeback, or signals store completion.

---
 rtl/mem_access_unit.sv | 274 +++++++++++++++++++++++++++
 tb/tb_mem_access_unit.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// mem_access_unit: memory-access stage between decode/execute and writeback.
// Accepts one load/store at a time and drives a word-addressed data-memory
// bus with a req/ack handshake. Load results are shifted to byte 0 and then
// sign- or zero-extended. Stores are lane-aligned with byte-lane strobes.
//
// Optional build macro MEM_ACCESS_SPLIT_EN: a misaligned H/W access is split
// into two word accesses (ACCESS -> ACCESS2) instead of raising err.
//
// Ports:
//   clk, rst                   clock, async active-high reset
//   in_valid / in_ready        request handshake from decode/execute
//   in_mem_op, in_mem_sel      operation (none/load/store/illegal) and size/sign
//   in_addr, in_wdata, in_rd   effective byte address, store data, load dest
//   dmem_req/we/addr/wstrb/wdata, dmem_ack/rdata   data-memory bus
//   wb_valid, wb_rd, wb_data   load result (pulse; rd/data held afterwards)
//   st_done                    store completion pulse
//   err                        misaligned/illegal access pulse
module mem_access_unit #(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_mem_op,
  input  logic [2:0]        in_mem_sel,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [31:0]       in_wdata,
  input  logic [4:0]        in_rd,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [3:0]        dmem_wstrb,
  output logic [31:0]       dmem_wdata,
  input  logic              dmem_ack,
  input  logic [31:0]       dmem_rdata,
  output logic              wb_valid,
  output logic [4:0]        wb_rd,
  output logic [31:0]       wb_data,
  output logic              st_done,
  output logic              err
);

`ifdef MEM_ACCESS_SPLIT_EN
  localparam bit SPLIT_EN = 1'b1;
`else
  localparam bit SPLIT_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACCESS,
    S_ACCESS2,
    S_DONE,
    S_FAULT
  } state_t;

  state_t state_q, state_d;

  // Latched request context
  logic        is_store_q, is_store_d;
  logic [2:0]  sel_q, sel_d;
  logic [1:0]  off_q, off_d;
  logic [4:0]  rd_q, rd_d;
  logic        split_q, split_d;
  logic [31:0] rdata1_q, rdata1_d;
  logic [3:0]  wstrb_hi_q, wstrb_hi_d;
  logic [31:0] wdata_hi_q, wdata_hi_d;

  // Next values of registered outputs
  logic              in_ready_d, req_d, we_d, wb_valid_d, st_done_d, err_d;
  logic [ADDR_W-1:0] addr_d;
  logic [3:0]        wstrb_d;
  logic [31:0]       wdata_d, wb_data_d;
  logic [4:0]        wb_rd_d;

  // Request classification
  logic        req_illegal, req_misaligned, req_store;
  logic [3:0]  strb_pat;
  logic [7:0]  strb8;
  logic [63:0] wdata_sh;
  logic [31:0] wdata_rep;
  logic [31:0] load_word, load_ext;

  assign req_store      = (in_mem_op == 2'b10);
  assign req_illegal    = (in_mem_op == 2'b11) || (in_mem_sel == 3'b011) ||
                          (in_mem_sel[2:1] == 2'b11) || (req_store && in_mem_sel[2]);
  assign req_misaligned = ((in_mem_sel[1:0] == 2'b01) && in_addr[0]) ||
                          ((in_mem_sel[1:0] == 2'b10) && (in_addr[1:0] != 2'b00));

  always_comb begin
    case (in_mem_sel[1:0])
      2'b00:   strb_pat = 4'b0001;
      2'b01:   strb_pat = 4'b0011;
      default: strb_pat = 4'b1111;
    endcase
  end

  // 8-lane strobe/data window spanning the addressed word and the next one
  assign strb8    = {4'b0000, strb_pat} << in_addr[1:0];
  assign wdata_sh = {32'b0, in_wdata} << {in_addr[1:0], 3'b000};

  always_comb begin
    case (in_mem_sel[1:0])
      2'b00:   wdata_rep = {4{in_wdata[7:0]}};
      2'b01:   wdata_rep = {2{in_wdata[15:0]}};
      default: wdata_rep = in_wdata;
    endcase
  end

  // Load byte window: second word (if split) sits above the first
  assign load_word = 32'((split_q ? {dmem_rdata, rdata1_q} : {32'b0, dmem_rdata})
                         >> {off_q, 3'b000});

  always_comb begin
    case (sel_q)
      3'b000:  load_ext = {{24{load_word[7]}}, load_word[7:0]};
      3'b001:  load_ext = {{16{load_word[15]}}, load_word[15:0]};
      3'b100:  load_ext = {24'b0, load_word[7:0]};
      3'b101:  load_ext = {16'b0, load_word[15:0]};
      default: load_ext = load_word;
    endcase
  end

  // Next-state and registered-output logic
  always_comb begin
    logic finish;
    logic hold;
    finish      = 1'b0;
    hold        = 1'b0;
    state_d     = state_q;
    in_ready_d  = 1'b0;
    req_d       = 1'b0;
    we_d        = 1'b0;
    addr_d      = '0;
    wstrb_d     = '0;
    wdata_d     = '0;
    wb_valid_d  = 1'b0;
    wb_rd_d     = wb_rd;
    wb_data_d   = wb_data;
    st_done_d   = 1'b0;
    err_d       = 1'b0;
    is_store_d  = is_store_q;
    sel_d       = sel_q;
    off_d       = off_q;
    rd_d        = rd_q;
    split_d     = split_q;
    rdata1_d    = rdata1_q;
    wstrb_hi_d  = wstrb_hi_q;
    wdata_hi_d  = wdata_hi_q;

    case (state_q)
      S_IDLE: begin
        in_ready_d = 1'b1;
        if (in_valid && (in_mem_op != 2'b00)) begin
          in_ready_d = 1'b0;
          is_store_d = req_store;
          sel_d      = in_mem_sel;
          off_d      = in_addr[1:0];
          rd_d       = in_rd;
          split_d    = req_misaligned;
          wstrb_hi_d = req_store ? strb8[7:4] : 4'b0000;
          wdata_hi_d = wdata_sh[63:32];
          if (req_illegal || (req_misaligned && !SPLIT_EN)) begin
            state_d = S_FAULT;
            err_d   = 1'b1;
          end else begin
            state_d = S_ACCESS;
            req_d   = 1'b1;
            we_d    = req_store;
            addr_d  = {in_addr[ADDR_W-1:2], 2'b00};
            wstrb_d = req_store ? strb8[3:0] : 4'b0000;
            wdata_d = !req_store ? 32'b0 : (req_misaligned ? wdata_sh[31:0] : wdata_rep);
          end
        end
      end
      S_ACCESS: begin
        if (dmem_ack && split_q) begin
          state_d  = S_ACCESS2;
          rdata1_d = dmem_rdata;
          req_d    = 1'b1;
          we_d     = is_store_q;
          addr_d   = dmem_addr + ADDR_W'(4);
          wstrb_d  = wstrb_hi_q;
          wdata_d  = is_store_q ? wdata_hi_q : 32'b0;
        end else if (dmem_ack) begin
          finish = 1'b1;
        end else begin
          hold = 1'b1;
        end
      end
      S_ACCESS2: begin
        if (dmem_ack) finish = 1'b1;
        else          hold   = 1'b1;
      end
      S_DONE, S_FAULT: begin
        state_d    = S_IDLE;
        in_ready_d = 1'b1;
      end
      default: begin
        state_d    = S_IDLE;
        in_ready_d = 1'b1;
      end
    endcase

    // Keep the bus stable until the access is acknowledged
    if (hold) begin
      req_d   = 1'b1;
      we_d    = dmem_we;
      addr_d  = dmem_addr;
      wstrb_d = dmem_wstrb;
      wdata_d = dmem_wdata;
    end

    if (finish) begin
      state_d = S_DONE;
      if (is_store_q) begin
        st_done_d = 1'b1;
      end else begin
        wb_valid_d = 1'b1;
        wb_rd_d    = rd_q;
        wb_data_d  = load_ext;
      end
    end
  end

  // State and output registers; reset drops dmem_req immediately
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      in_ready   <= 1'b1;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_wstrb <= '0;
      dmem_wdata <= '0;
      wb_valid   <= 1'b0;
      wb_rd      <= '0;
      wb_data    <= '0;
      st_done    <= 1'b0;
      err        <= 1'b0;
      is_store_q <= 1'b0;
      sel_q      <= '0;
      off_q      <= '0;
      rd_q       <= '0;
      split_q    <= 1'b0;
      rdata1_q   <= '0;
      wstrb_hi_q <= '0;
      wdata_hi_q <= '0;
    end else begin
      state_q    <= state_d;
      in_ready   <= in_ready_d;
      dmem_req   <= req_d;
      dmem_we    <= we_d;
      dmem_addr  <= addr_d;
      dmem_wstrb <= wstrb_d;
      dmem_wdata <= wdata_d;
      wb_valid   <= wb_valid_d;
      wb_rd      <= wb_rd_d;
      wb_data    <= wb_data_d;
      st_done    <= st_done_d;
      err        <= err_d;
      is_store_q <= is_store_d;
      sel_q      <= sel_d;
      off_q      <= off_d;
      rd_q       <= rd_d;
      split_q    <= split_d;
      rdata1_q   <= rdata1_d;
      wstrb_hi_q <= wstrb_hi_d;
      wdata_hi_q <= wdata_hi_d;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: a byte-addressed reference memory
// predicts every response and bus access; a bus responder and a response
// monitor pop and compare independently of the stimulus.
module tb_mem_access_unit;
  localparam int unsigned ADDR_W = 32;
`ifdef MEM_ACCESS_SPLIT_EN
  localparam bit SPLIT = 1'b1;
`else
  localparam bit SPLIT = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic in_ready;
  logic [1:0] in_mem_op = '0;
  logic [2:0] in_mem_sel = '0;
  logic [ADDR_W-1:0] in_addr = '0;
  logic [31:0] in_wdata = '0;
  logic [4:0] in_rd = '0;
  logic dmem_req, dmem_we;
  logic [ADDR_W-1:0] dmem_addr;
  logic [3:0] dmem_wstrb;
  logic [31:0] dmem_wdata;
  logic dmem_ack = 1'b0;
  logic [31:0] dmem_rdata = '0;
  logic wb_valid, st_done, err;
  logic [4:0] wb_rd;
  logic [31:0] wb_data;

  always #5 clk = ~clk;

  mem_access_unit #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_mem_op(in_mem_op), .in_mem_sel(in_mem_sel), .in_addr(in_addr),
    .in_wdata(in_wdata), .in_rd(in_rd),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wstrb(dmem_wstrb), .dmem_wdata(dmem_wdata),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .st_done(st_done), .err(err)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct { int kind; logic [4:0] rd; logic [31:0] data; int acc_cyc; int exp_per; } resp_t;
  typedef struct { logic [31:0] addr; bit we; logic [3:0] strb; logic [31:0] data; } bus_t;
  resp_t resp_q[$];
  bus_t  bus_q[$];

  // Reference byte memory and the bus-side word memory start with identical content
  logic [7:0]  ref_mem [int unsigned];
  logic [31:0] bus_mem [int unsigned];

  function automatic logic [7:0] def_byte(input int unsigned a);
    return 8'(a * 37 + 11);
  endfunction

  function automatic logic [7:0] ref_rd(input int unsigned a);
    return ref_mem.exists(a) ? ref_mem[a] : def_byte(a);
  endfunction

  function automatic logic [31:0] bus_rd(input int unsigned wa);
    logic [31:0] w;
    if (bus_mem.exists(wa)) return bus_mem[wa];
    for (int j = 0; j < 4; j++) w[8*j +: 8] = def_byte(wa + j);
    return w;
  endfunction

  task automatic preload(input int unsigned wa, input logic [31:0] v);
    bus_mem[wa] = v;
    for (int j = 0; j < 4; j++) ref_mem[wa + j] = v[8*j +: 8];
  endtask

  int force_wait = -1;

  // Predict the outcome from byte-level semantics, then hand the request to the DUT
  task automatic issue(input logic [1:0] op, input logic [2:0] sel, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [4:0] rd, input bit track = 1'b1);
    resp_t r;
    bus_t  bq[$];
    int size, nacc, guard;
    bit illegal, mis;
    logic [31:0] raw;
    size    = (sel[1:0] == 2'b00) ? 1 : (sel[1:0] == 2'b01) ? 2 : 4;
    illegal = (op == 2'b11) || (sel == 3'd3) || (sel == 3'd6) || (sel == 3'd7) ||
              (op == 2'b10 && (sel == 3'd4 || sel == 3'd5));
    mis     = (addr % size) != 0;
    nacc    = mis ? 2 : 1;
    r = '{kind: 2, rd: '0, data: '0, acc_cyc: 0, exp_per: 0};
    if (op != 2'b00 && !(illegal || (mis && !SPLIT))) begin
      for (int k = 0; k < nacc; k++) begin
        bus_t b;
        b.addr = (addr & ~32'd3) + 32'(4 * k);
        b.we = (op == 2'b10);
        b.strb = '0;
        b.data = '0;
        for (int j = 0; j < 4; j++) begin
          int unsigned ba;
          ba = b.addr + j;
          if (b.we && ba >= addr && ba < addr + size) begin
            b.strb[j] = 1'b1;
            b.data[8*j +: 8] = wdata[8*(ba - addr) +: 8];
          end
        end
        bq.push_back(b);
      end
      if (op == 2'b01) begin
        raw = '0;
        for (int i = 0; i < size; i++) raw[8*i +: 8] = ref_rd(addr + i);
        if (size == 1 && sel == 3'd0) raw = {{24{raw[7]}}, raw[7:0]};
        if (size == 2 && sel == 3'd1) raw = {{16{raw[15]}}, raw[15:0]};
        r.kind = 0; r.rd = rd; r.data = raw;
      end else begin
        for (int i = 0; i < size; i++) ref_mem[addr + i] = wdata[8*i +: 8];
        r.kind = 1;
      end
      if (force_wait >= 0) r.exp_per = 1 + nacc * (1 + force_wait);
    end
    guard = 0;
    @(negedge clk);
    while (!in_ready && guard < 200) begin @(negedge clk); guard++; end
    if (!in_ready) begin check("accept_timeout", in_ready, 1); return; end
    in_mem_op = op; in_mem_sel = sel; in_addr = addr; in_wdata = wdata; in_rd = rd;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_mem_op = 2'($urandom); in_mem_sel = 3'($urandom); in_addr = $urandom;
    if (track && op != 2'b00) begin
      r.acc_cyc = cyc;
      resp_q.push_back(r);
      foreach (bq[i]) bus_q.push_back(bq[i]);
    end
  endtask

  task automatic drain();
    int g;
    g = 0;
    while ((resp_q.size() != 0 || bus_q.size() != 0) && g < 500) begin @(negedge clk); g++; end
    repeat (2) @(negedge clk);
  endtask

  // Bus responder: random or forced wait states, spurious acks when idle
  bit in_acc = 1'b0;
  int wait_left = 0, req_cycles = 0, last_req_cycles = 0;
  logic [31:0] held_addr, last_addr, last_wdata;
  logic [36:0] held_ctl;
  logic [3:0]  last_strb;
  logic        last_we;
  always @(negedge clk) begin
    if (rst) begin
      dmem_ack = 1'b1;
      dmem_rdata = $urandom;
      in_acc = 1'b0;
    end else if (!dmem_req) begin
      dmem_ack = ($urandom_range(0, 3) == 0);
      dmem_rdata = $urandom;
      in_acc = 1'b0;
    end else begin
      check("in_ready_busy", in_ready, 0);
      if (!in_acc) begin
        in_acc = 1'b1;
        wait_left = (force_wait >= 0) ? force_wait : $urandom_range(0, 3);
        req_cycles = 0;
        held_addr = dmem_addr;
        held_ctl = {dmem_we, dmem_wstrb, dmem_wdata};
      end else begin
        check("hold_addr", dmem_addr, held_addr);
        check("hold_ctl", {dmem_we, dmem_wstrb, dmem_wdata}, held_ctl);
      end
      req_cycles++;
      if (wait_left == 0) begin
        logic [31:0] w, lm;
        dmem_ack = 1'b1;
        in_acc = 1'b0;
        last_req_cycles = req_cycles;
        last_addr = dmem_addr; last_wdata = dmem_wdata; last_strb = dmem_wstrb; last_we = dmem_we;
        if (bus_q.size() == 0) begin
          check("bus_unexpected", dmem_req, 0);
        end else begin
          bus_t e;
          e = bus_q.pop_front();
          for (int j = 0; j < 4; j++) lm[8*j +: 8] = {8{e.strb[j]}};
          check("bus_addr", dmem_addr, e.addr);
          check("bus_we", dmem_we, e.we);
          check("bus_wstrb", dmem_wstrb, e.strb);
          check("bus_wdata", dmem_wdata & lm, e.data);
        end
        w = bus_rd(dmem_addr);
        dmem_rdata = w;
        if (dmem_we) begin
          for (int j = 0; j < 4; j++) if (dmem_wstrb[j]) w[8*j +: 8] = dmem_wdata[8*j +: 8];
          bus_mem[dmem_addr] = w;
        end
      end else begin
        dmem_ack = 1'b0;
        dmem_rdata = $urandom;
        wait_left--;
      end
    end
  end

  // Response monitor: pops the scoreboard whenever a pulse appears
  always @(negedge clk) begin
    if (!rst && (wb_valid || st_done || err)) begin
      if (resp_q.size() == 0) begin
        check("resp_unexpected", {wb_valid, st_done, err}, 0);
      end else begin
        resp_t r;
        r = resp_q.pop_front();
        check("resp_kind", {wb_valid, st_done, err}, 3'b100 >> r.kind);
        if (r.kind == 0) begin
          check("wb_rd", wb_rd, r.rd);
          check("wb_data", wb_data, r.data);
        end
        if (r.kind == 2) check("err_no_bus", dmem_req, 0);
        if (r.exp_per > 0) check("latency", cyc - r.acc_cyc + 1, r.exp_per);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int g;
    logic [1:0] op;
    repeat (2) @(negedge clk);
    check("reset_in_ready", in_ready, 1);
    check("reset_ctl", {dmem_req, dmem_we, dmem_wstrb, wb_valid, st_done, err, wb_rd}, 0);
    check("reset_addr", dmem_addr, 0);
    check("reset_data", {wb_data, dmem_wdata}, 0);
    #2 rst = 1'b0;

    // LB sign-extension with zero-wait ack
    preload(32'h1000, 32'h80FF_0000);
    force_wait = 0;
    issue(2'b01, 3'b000, 32'h1003, 32'h0, 5'd2);
    drain();
    check("wb_hold_data", wb_data, 32'hFFFF_FF80);
    check("wb_hold_rd", wb_rd, 2);

    // LHU with wait states: req held three cycles
    preload(32'h2000, 32'hBEEF_1234);
    force_wait = 2;
    issue(2'b01, 3'b101, 32'h2002, 32'h0, 5'd6);
    drain();
    check("lhu_req_cycles", last_req_cycles, 3);

    // SB to byte 3 replicates data across lanes
    force_wait = 0;
    issue(2'b10, 3'b000, 32'h0000_0013, 32'h1234_56AB, 5'd0);
    drain();
    check("sb_addr", last_addr, 32'h10);
    check("sb_wstrb", last_strb, 4'b1000);
    check("sb_wdata_full", last_wdata, 32'hABAB_ABAB);
    check("sb_we", last_we, 1);

    // Misaligned LW: fault, or split access when enabled
    preload(32'h4000, 32'h1122_3344);
    preload(32'h4004, 32'h5566_7788);
    issue(2'b01, 3'b010, 32'h4002, 32'h0, 5'd9);
    // Illegal store-unsigned, illegal sel, illegal op
    issue(2'b10, 3'b100, 32'h4000, 32'hDEAD_BEEF, 5'd1);
    issue(2'b01, 3'b111, 32'h4000, 32'h0, 5'd1);
    issue(2'b11, 3'b010, 32'h4000, 32'h0, 5'd1);
    drain();

    // Reset during a wait state discards the access
    force_wait = 20;
    issue(2'b01, 3'b010, 32'h40, 32'h0, 5'd3, 1'b0);
    g = 0;
    while (!dmem_req && g < 20) begin @(negedge clk); g++; end
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("rst_req_drop", dmem_req, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_pulses", {wb_valid, st_done, err}, 0);
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    force_wait = 0;
    issue(2'b01, 3'b010, 32'h0, 32'h0, 5'd4);
    drain();

    // Randomized traffic in a small window so loads see earlier stores
    force_wait = -1;
    for (int i = 0; i < 300; i++) begin
      int r;
      r = $urandom_range(0, 9);
      op = (r == 0) ? 2'b00 : (r < 5) ? 2'b01 : (r < 9) ? 2'b10 : 2'b11;
      issue(op, 3'($urandom_range(0, 7)), 32'h100 + $urandom_range(0, 31),
            $urandom, 5'($urandom_range(0, 31)));
    end
    drain();
    check("resp_q_empty", resp_q.size(), 0);
    check("bus_q_empty", bus_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
